// File: rtl/inport_reader_if.sv
// Bus-side handshake between an inport_reader (master) and its inport peripheral (slave).
// The peripheral drives bus_d onto the shared bus only while oe is high.
interface inport_reader_if #(
   parameter int WIDTH = 8
);
   logic             oe;
   logic             ok2send;
   logic             ready;
   logic [WIDTH-1:0] bus_d;

   modport master (
      output oe,
      output ok2send,
      input  ready,
      input  bus_d
   );

   modport slave (
      input  oe,
      input  ok2send,
      output ready,
      output bus_d
   );
endinterface

// File: rtl/inport_reader.sv
// Pulls words from an inport peripheral via the oe/ok2send handshake into a small FWFT FIFO.
// Optional REQ timeout with sticky err flag: define INPORT_READER_TIMEOUT_EN.
module inport_reader #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   inport_reader_if.master         bus,
   output logic                    rd_valid,
   output logic [WIDTH-1:0]        rd_data,
   input  logic                    rd_pop,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("inport_reader: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK,
      RELEASE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             push;
   logic             pop;
   logic             timeout_hit;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // A transaction only starts with a free slot, so the REQ->ACK capture can never overflow.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (en && count != FULL) state_next = REQ;
         end
         REQ: begin
            if (bus.ready) begin
               push       = 1'b1;
               state_next = ACK;
            end else if (timeout_hit) begin
               state_next = RELEASE;
            end
         end
         ACK: begin
            if (!bus.ready) state_next = RELEASE;
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // oe/ok2send decode the next state so they are glitch-free registers toward the peripheral.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bus.oe      <= 1'b0;
         bus.ok2send <= 1'b0;
      end else begin
         state       <= state_next;
         bus.oe      <= (state_next == REQ) || (state_next == ACK);
         bus.ok2send <= (state_next == ACK);
      end
   end

   assign rd_valid = (count != '0);
   assign pop      = rd_pop && rd_valid;
   assign rd_data  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.bus_d;
   end

`ifdef INPORT_READER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] wait_cnt;

   assign timeout_hit = (state == REQ) && !bus.ready && (wait_cnt == TLAST);

   // wait_cnt idles at zero outside REQ, so every REQ entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state != REQ)    wait_cnt <= '0;
         else if (!bus.ready) wait_cnt <= wait_cnt + 1'b1;
         if (timeout_hit)     err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_inport_reader.sv
// Self-checking bench for inport_reader: a reactive inport model plus a queue-based FIFO/handshake reference.
module tb_inport_reader;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic                   rd_pop;
   logic                   rd_valid;
   logic                   err;
   logic [WIDTH-1:0]       rd_data;
   logic [$clog2(DEPTH):0] count;

   inport_reader_if #(.WIDTH(WIDTH)) bus_if ();

   inport_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .bus      (bus_if.master),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_pop   (rd_pop),
      .count    (count),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compares   = 0;
   int mismatches = 0;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] word_src[$];
   logic [WIDTH-1:0] next_word;
   int  delay_min, delay_max, hold_min, hold_max;
   int  req_delay_left, hold_left;
   int  low_cycles, req_cycles;
   bit  exp_oe, exp_ok, exp_err;
   bit  pop_on_capture, last_capture;
   int  count_before;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compares++;
      assert (obs === expv) else begin
         mismatches++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [WIDTH-1:0] pick_word();
      if (word_src.size() > 0) return word_src.pop_front();
      return WIDTH'($urandom);
   endfunction

   task automatic new_transaction();
      next_word      = pick_word();
      req_delay_left = int'($urandom_range(delay_max, delay_min));
   endtask

   // One clock: called just after a negedge, drives inputs, advances the model, checks at the next negedge.
   task automatic applyStimulus(input bit en_v, input bit pop_v);
      bit captured, fall, rise;
      en = en_v;
      if (!bus_if.oe) begin
         bus_if.ready = 1'b0;
         bus_if.bus_d = WIDTH'($urandom);
      end else if (!bus_if.ok2send) begin
         if (req_delay_left == 0) begin
            bus_if.ready = 1'b1;
            bus_if.bus_d = next_word;
         end else begin
            req_delay_left--;
            bus_if.ready = 1'b0;
            bus_if.bus_d = WIDTH'($urandom);
         end
      end else begin
         bus_if.bus_d = WIDTH'($urandom);
         if (hold_left > 0) begin
            hold_left--;
            bus_if.ready = 1'b1;
         end else begin
            bus_if.ready = 1'b0;
         end
      end

      captured     = exp_oe && !exp_ok && bus_if.ready;
      last_capture = captured;
      rd_pop       = pop_v || (pop_on_capture && captured);
      if (exp_oe && !exp_ok) req_cycles++;
      else req_cycles = 0;
      fall = exp_ok && !bus_if.ready;
`ifdef INPORT_READER_TIMEOUT_EN
      if (exp_oe && !exp_ok && !bus_if.ready && req_cycles == TIMEOUT) begin
         fall    = 1'b1;
         exp_err = 1'b1;
      end
`endif
      rise = !exp_oe && low_cycles >= 2 && en_v && exp_q.size() < DEPTH;

      if (rd_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (captured) begin
         exp_q.push_back(next_word);
         hold_left = int'($urandom_range(hold_max, hold_min));
         new_transaction();
      end

      if (exp_ok) begin
         exp_ok = !fall;
         exp_oe = !fall;
      end else if (exp_oe) begin
         exp_ok = captured;
         exp_oe = !fall;
      end else begin
         exp_oe = rise;
      end
      if (exp_oe) low_cycles = 0;
      else low_cycles++;

      @(posedge clk);
      @(negedge clk);
      checkOutput("oe", 32'(bus_if.oe), 32'(exp_oe));
      checkOutput("ok2send", 32'(bus_if.ok2send), 32'(exp_ok));
      checkOutput("count", 32'(count), 32'(exp_q.size()));
      checkOutput("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(exp_q[0]));
      checkOutput("err", 32'(err), 32'(exp_err));
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      en           = 1'b0;
      rd_pop       = 1'b0;
      bus_if.ready = 1'b0;
      bus_if.bus_d = '0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_oe         = 1'b0;
      exp_ok         = 1'b0;
      exp_err        = 1'b0;
      low_cycles     = 2;
      req_cycles     = 0;
      pop_on_capture = 1'b0;
      hold_left      = 0;
      checkOutput("reset_oe", 32'(bus_if.oe), 32'd0);
      checkOutput("reset_ok2send", 32'(bus_if.ok2send), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      new_transaction();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      delay_min = 0;
      delay_max = 0;
      hold_min  = 1;
      hold_max  = 1;
      word_src  = '{8'h05};
      do_reset();

      // Single read with a one-cycle en pulse and nominal peripheral timing.
      applyStimulus(1'b1, 1'b0);
      checkOutput("single_oe_rise", 32'(bus_if.oe), 32'd1);
      checkOutput("single_ok_low_at_rise", 32'(bus_if.ok2send), 32'd0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("single_count", 32'(count), 32'd1);
      checkOutput("single_data", 32'(rd_data), 32'h05);
      checkOutput("single_ok_high", 32'(bus_if.ok2send), 32'd1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("single_ack_hold", 32'(bus_if.ok2send), 32'd1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("single_oe_fall", 32'(bus_if.oe), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      checkOutput("single_idle_oe", 32'(bus_if.oe), 32'd0);
      checkOutput("single_idle_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("single_popped", 32'(rd_valid), 32'd0);

      // Burst fill to full with en held high, then park.
      word_src = '{8'h01, 8'h02, 8'h03, 8'h04};
      new_transaction();
      repeat (30) applyStimulus(1'b1, 1'b0);
      checkOutput("burst_count_full", 32'(count), 32'd4);
      checkOutput("burst_parked_oe", 32'(bus_if.oe), 32'd0);
      checkOutput("burst_head", 32'(rd_data), 32'h01);

      // Push and pop on the same edge at count 3.
      word_src = '{8'hA5};
      new_transaction();
      pop_on_capture = 1'b1;
      applyStimulus(1'b1, 1'b1);
      checkOutput("bnd_count_pre", 32'(count), 32'd3);
      last_capture = 1'b0;
      for (int i = 0; i < 10 && !last_capture; i++) applyStimulus(1'b1, 1'b0);
      pop_on_capture = 1'b0;
      checkOutput("bnd_capture_seen", 32'(last_capture), 32'd1);
      checkOutput("bnd_count", 32'(count), 32'd3);
      checkOutput("bnd_head", 32'(rd_data), 32'h03);
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain_4", 32'(rd_data), 32'h04);
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain_a5", 32'(rd_data), 32'hA5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("drain_empty", 32'(rd_valid), 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("pop_empty_ignored", 32'(count), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0);

      // Asynchronous reset while in ACK.
      word_src = '{8'h3C};
      hold_min = 2;
      hold_max = 2;
      new_transaction();
      for (int i = 0; i < 10 && !exp_ok; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("ack_reached", 32'(bus_if.ok2send), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_oe", 32'(bus_if.oe), 32'd0);
      checkOutput("async_ok2send", 32'(bus_if.ok2send), 32'd0);
      checkOutput("async_count", 32'(count), 32'd0);
      checkOutput("async_rd_valid", 32'(rd_valid), 32'd0);
      do_reset();

      // Randomized traffic with variable peripheral latency, en and pops.
      delay_min = 0;
      delay_max = 3;
      hold_min  = 0;
      hold_max  = 2;
      new_transaction();
      for (int i = 0; i < 600; i++)
         applyStimulus($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 35);

`ifdef INPORT_READER_TIMEOUT_EN
      repeat (12) applyStimulus(1'b0, 1'b1);
      delay_min = 1000;
      delay_max = 1000;
      new_transaction();
      count_before = exp_q.size();
      applyStimulus(1'b1, 1'b0);
      repeat (25) applyStimulus(1'b0, 1'b0);
      checkOutput("to_err", 32'(err), 32'd1);
      checkOutput("to_count", 32'(count), 32'(count_before));
      delay_min = 0;
      delay_max = 0;
      hold_min  = 1;
      hold_max  = 1;
      new_transaction();
      repeat (12) applyStimulus(1'b1, 1'b0);
      checkOutput("to_err_sticky", 32'(err), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
